// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    localparam int unsigned CLK_PER_BIT_115200_50M = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-cell timer: counts 0..CLK_PER_BIT-1, held at zero while clear is high.
module uart_baud_gen import uart_pkg::*; #(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_115200_50M
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a small input FIFO; queued words go out
// back-to-back with the next start bit directly after the last stop bit.
module uart_tx_frame import uart_pkg::*; #(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_115200_50M,
    parameter int unsigned DATA_BITS   = 8,
    parameter parity_e     PARITY      = PAR_NONE,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    input  logic [DATA_BITS-1:0]             in_data,
    output logic                             in_ready,
    output logic                             txd,
    output logic                             busy,
    output logic                             frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          used;
    logic [DATA_BITS-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    tx_state_e            state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [3:0]           bit_cnt;
    logic                 tick;
    logic                 last_data;
    logic                 last_stop;
    logic                 line_bit;

    assign used       = wr_ptr - rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign fifo_count = CNTW'(used);
    assign head       = mem[rd_ptr[AW-1:0]];

    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

    // Pop either from idle or on the final stop tick, so the next start bit follows without a gap.
    assign pop = !empty && ((state == IDLE) || ((state == STOP) && tick && last_stop));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= in_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    uart_baud_gen #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
        .clk   (clk),
        .rstn  (rstn),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:            line_bit = 1'b0;
            DATA:             line_bit = shreg[0];
            uart_pkg::PARITY: line_bit = par_bit;
            default:          line_bit = 1'b1;
        endcase
    end

    // txd trails the state by one cycle; busy is held until frame_done has been seen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            txd        <= line_bit;
            frame_done <= (state == STOP) && tick && last_stop;
            if (pop) begin
                shreg   <= head;
                par_bit <= (PARITY == PAR_ODD) ^ (^head);
                bit_cnt <= '0;
                state   <= START;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_done) busy <= 1'b0;
                    end
                    START: begin
                        if (tick) state <= DATA;
                    end
                    DATA: begin
                        if (tick) begin
                            shreg <= shreg >> 1;
                            if (last_data) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    uart_pkg::PARITY: begin
                        if (tick) state <= STOP;
                    end
                    STOP: begin
                        if (tick) begin
                            if (last_stop) state <= IDLE;
                            else           bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Three transmitter configurations (8N1, 7E1, 8O2) checked cycle by cycle
// against a line-schedule model built from frame rules.
module tb_uart_tx_frame;
    import uart_pkg::*;

    typedef struct packed {
        logic t;
        logic d;
    } cell_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int unsigned CPB = 4;
        localparam int unsigned DB  = (g == 1) ? 7 : 8;
        localparam parity_e     PM  = (g == 0) ? PAR_NONE : (g == 1) ? PAR_EVEN : PAR_ODD;
        localparam int unsigned SB  = (g == 2) ? 2 : 1;
        localparam int unsigned DEP = (g == 2) ? 2 : 4;
        localparam int unsigned CW  = $clog2(DEP + 1);

        logic          rstn     = 1'b0;
        logic          in_valid = 1'b0;
        logic [DB-1:0] in_data  = '0;
        logic          in_ready;
        logic          txd;
        logic          busy;
        logic          frame_done;
        logic [CW-1:0] fifo_count;

        // Model: words waiting in the FIFO, and the txd value for each future cycle.
        logic [DB-1:0] mq[$];
        cell_t         lq[$];
        bit            done_f = 1'b0;

        uart_tx_frame #(
            .CLK_PER_BIT (CPB),
            .DATA_BITS   (DB),
            .PARITY      (PM),
            .STOP_BITS   (SB),
            .FIFO_DEPTH  (DEP)
        ) dut (
            .clk        (clk),
            .rstn       (rstn),
            .in_valid   (in_valid),
            .in_data    (in_data),
            .in_ready   (in_ready),
            .txd        (txd),
            .busy       (busy),
            .frame_done (frame_done),
            .fifo_count (fifo_count)
        );

        function automatic void add_frame(input logic [DB-1:0] w);
            logic b[$];
            b.push_back(1'b0);
            for (int i = 0; i < int'(DB); i++) b.push_back(w[i]);
            if (PM != PAR_NONE) b.push_back((($countones(w) % 2) == 1) ^ (PM == PAR_ODD));
            for (int i = 0; i < int'(SB); i++) b.push_back(1'b1);
            foreach (b[j]) begin
                for (int c = 0; c < int'(CPB); c++) begin
                    lq.push_back('{t: b[j], d: (j == int'(b.size()) - 1) && (c == int'(CPB) - 1)});
                end
            end
        endfunction

        task automatic step(input logic v, input logic [DB-1:0] d, input logic r, output logic acc);
            cell_t c;
            logic  have;
            @(negedge clk);
            rstn     = r;
            in_valid = v;
            in_data  = d;
            acc  = 1'b0;
            have = 1'b0;
            c    = '0;
            if (!r) begin
                mq.delete();
                lq.delete();
            end else begin
                acc = v && (mq.size() < int'(DEP));
                if (lq.size() <= 1 && mq.size() != 0) begin
                    if (lq.size() == 0) lq.push_back('{t: 1'b1, d: 1'b0});
                    add_frame(mq.pop_front());
                end
                if (acc) mq.push_back(d);
                if (lq.size() != 0) begin
                    c    = lq.pop_front();
                    have = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            check($sformatf("%0d.txd", g),        32'(txd),        have ? 32'(c.t) : 32'd1);
            check($sformatf("%0d.busy", g),       32'(busy),       32'(have));
            check($sformatf("%0d.frame_done", g), 32'(frame_done), 32'(c.d));
            check($sformatf("%0d.fifo_count", g), 32'(fifo_count), 32'(mq.size()));
            check($sformatf("%0d.in_ready", g),   32'(in_ready),   32'(mq.size() < int'(DEP)));
        endtask

        task automatic drain();
            logic a;
            for (int i = 0; i < 3000 && (lq.size() != 0 || mq.size() != 0); i++) step(1'b0, '0, 1'b1, a);
            step(1'b0, '0, 1'b1, a);
            step(1'b0, '0, 1'b1, a);
        endtask

        initial begin
            logic          a;
            logic [DB-1:0] w;
            int unsigned   k;

            for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, a);
            for (int i = 0; i < 100; i++) step(1'b0, '0, 1'b1, a);

            w = DB'((g == 0) ? 'hA5 : (g == 1) ? 'h35 : 'hFF);
            step(1'b1, w, 1'b1, a);
            drain();

            k = 1;
            for (int i = 0; i < 1000 && k <= 5; i++) begin
                step(1'b1, DB'(k), 1'b1, a);
                if (a) k++;
            end
            drain();

            for (int i = 0; i < 600; i++) begin
                w = DB'($urandom);
                step(logic'($urandom_range(0, 3) == 0), w, 1'b1, a);
            end
            drain();

            // Reset lands inside data bit 3 of the first frame with two words still queued.
            step(1'b1, DB'('hA5), 1'b1, a);
            step(1'b1, DB'('h3C), 1'b1, a);
            step(1'b1, DB'('h5A), 1'b1, a);
            for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, a);
            step(1'b0, '0, 1'b0, a);
            for (int i = 0; i < 60; i++) step(1'b0, '0, 1'b1, a);
            drain();

            done_f = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 100000 && !(u[0].done_f && u[1].done_f && u[2].done_f); i++) @(posedge clk);
        check("finish", 32'(u[0].done_f && u[1].done_f && u[2].done_f), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
